// File: rtl/calc_pkg.sv
// Shared encodings for the calculator key sequencer: FSM state codes,
// keypad class codes, control-decoder answers and ALU operation selects.
package calc_pkg;

    // FSM state codes; 3'b101 is not a legal state and is decoded as ERR.
    localparam logic [2:0] ST_IDLE   = 3'b000;
    localparam logic [2:0] ST_ENTA   = 3'b001;
    localparam logic [2:0] ST_OPSEL  = 3'b010;
    localparam logic [2:0] ST_ENTB   = 3'b011;
    localparam logic [2:0] ST_EXEC   = 3'b100;
    localparam logic [2:0] ST_UNUSED = 3'b101;
    localparam logic [2:0] ST_DONE   = 3'b110;
    localparam logic [2:0] ST_ERR    = 3'b111;

    // Keypad event classes.
    localparam logic [2:0] KC_DIGIT  = 3'b000;
    localparam logic [2:0] KC_ADD    = 3'b001;
    localparam logic [2:0] KC_SUB    = 3'b010;
    localparam logic [2:0] KC_MUL    = 3'b011;
    localparam logic [2:0] KC_EQUALS = 3'b100;
    localparam logic [2:0] KC_CLEAR  = 3'b101;
    localparam logic [2:0] KC_BACK   = 3'b110;
    localparam logic [2:0] KC_NONE   = 3'b111;

    // Answers from the external control decoder.
    localparam logic [1:0] CONT_REJECT  = 2'b00;
    localparam logic [1:0] CONT_ACCEPT  = 2'b01;
    localparam logic [1:0] CONT_COMMIT  = 2'b10;
    localparam logic [1:0] CONT_ILLEGAL = 2'b11;

    // ALU operation selects.
    localparam logic [1:0] OPS_ADD = 2'b00;
    localparam logic [1:0] OPS_SUB = 2'b01;
    localparam logic [1:0] OPS_MUL = 2'b10;

    // True for the three arithmetic operator keys.
    function automatic logic is_op_key(input logic [2:0] kc);
        return (kc == KC_ADD) || (kc == KC_SUB) || (kc == KC_MUL);
    endfunction

    // Operator key to ALU select (only meaningful when is_op_key is true).
    function automatic logic [1:0] op_sel_of(input logic [2:0] kc);
        logic [1:0] sel;
        case (kc)
            KC_SUB:  sel = OPS_SUB;
            KC_MUL:  sel = OPS_MUL;
            default: sel = OPS_ADD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/bcd_shift.sv
// Four-digit BCD operand helper: shift a new digit in from the right,
// drop the lowest digit (backspace), and flag a full operand.
module bcd_shift
    import calc_pkg::*;
(
    input  logic [15:0] op_i,
    input  logic [3:0]  digit_i,
    output logic [15:0] shin_o,
    output logic [15:0] shout_o,
    output logic        full_o
);

    // A nonzero top digit means there is no room for another digit; the
    // shift-in result then holds the operand unchanged.
    always_comb begin
        full_o  = |op_i[15:12];
        shin_o  = full_o ? op_i : {op_i[11:0], digit_i};
        shout_o = {4'h0, op_i[15:4]};
    end

endmodule

// File: rtl/calc_seq.sv
// Calculator keypad sequencer. Collects two BCD operands and an operator
// from a keypad stream, consults an external control decoder for every key,
// and issues an ALU request once equals is committed.
//
// Handshakes: a key is taken on a cycle where key_valid && key_ready; cont
// is sampled in that same cycle and every resulting register update lands
// on the closing clock edge. The ALU request is taken on a cycle where
// exec_valid && exec_ready; exec_valid stays high with stable operands
// until then.
module calc_seq
    import calc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [2:0]  key_class,
    input  logic [3:0]  key_digit,
    output logic        key_ready,
    output logic [5:0]  ctl_word,
    input  logic [1:0]  cont,
    output logic [15:0] op_a,
    output logic [15:0] op_b,
    output logic [1:0]  op_sel,
    output logic        exec_valid,
    input  logic        exec_ready,
    output logic        rej,
    output logic        ovf,
    output logic [2:0]  st
);

    logic [2:0]  state_q, state_d;
    logic [15:0] op_a_q, op_a_d;
    logic [15:0] op_b_q, op_b_d;
    logic [1:0]  op_sel_q, op_sel_d;
    logic        rej_q, rej_d;
    logic        ovf_q, ovf_d;

    logic [2:0]  cur_st;
    logic        key_hs;
    logic        bad_digit;

    logic [15:0] a_shin, a_shout;
    logic [15:0] b_shin, b_shout;
    logic        a_full, b_full;

    bcd_shift u_shift_a (
        .op_i    (op_a_q),
        .digit_i (key_digit),
        .shin_o  (a_shin),
        .shout_o (a_shout),
        .full_o  (a_full)
    );

    bcd_shift u_shift_b (
        .op_i    (op_b_q),
        .digit_i (key_digit),
        .shin_o  (b_shin),
        .shout_o (b_shout),
        .full_o  (b_full)
    );

    // Decode the current state (unused code folds to ERR) and the handshake.
    always_comb begin
        cur_st    = (state_q == ST_UNUSED) ? ST_ERR : state_q;
        key_ready = (cur_st != ST_EXEC);
        key_hs    = key_valid && key_ready;
        bad_digit = (key_class == KC_DIGIT) && (key_digit > 4'd9);
    end

    // Next-state and register update rules for one taken key or ALU accept.
    always_comb begin
        state_d  = cur_st;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        op_sel_d = op_sel_q;
        ovf_d    = ovf_q;
        rej_d    = 1'b0;

        if (key_hs) begin
            if (key_class == KC_CLEAR) begin
                // Clear wins over everything, including ERR and the decoder.
                state_d  = ST_IDLE;
                op_a_d   = 16'h0000;
                op_b_d   = 16'h0000;
                op_sel_d = OPS_ADD;
                ovf_d    = 1'b0;
            end else if (cur_st == ST_ERR) begin
                rej_d = 1'b1;
            end else if ((cont == CONT_REJECT) || bad_digit) begin
                rej_d = 1'b1;
            end else if (cont == CONT_ILLEGAL) begin
                state_d = ST_ERR;
            end else if (cont == CONT_ACCEPT) begin
                if (key_class == KC_DIGIT) begin
                    case (cur_st)
                        ST_IDLE, ST_DONE: begin
                            op_a_d  = {12'h000, key_digit};
                            state_d = ST_ENTA;
                        end
                        ST_ENTA: begin
                            op_a_d = a_shin;
                            if (a_full) ovf_d = 1'b1;
                        end
                        ST_OPSEL: begin
                            op_b_d  = {12'h000, key_digit};
                            state_d = ST_ENTB;
                        end
                        ST_ENTB: begin
                            op_b_d = b_shin;
                            if (b_full) ovf_d = 1'b1;
                        end
                        default: rej_d = 1'b1;
                    endcase
                end else if ((key_class == KC_BACK) && (cur_st == ST_ENTA)) begin
                    op_a_d = a_shout;
                end else if ((key_class == KC_BACK) && (cur_st == ST_ENTB)) begin
                    op_b_d = b_shout;
                end else begin
                    // Accepted by the decoder but meaningless here.
                    rej_d = 1'b1;
                end
            end else begin
                // Commit answers: operators and equals only.
                if (is_op_key(key_class) &&
                    ((cur_st == ST_ENTA) || (cur_st == ST_DONE))) begin
                    op_sel_d = op_sel_of(key_class);
                    state_d  = ST_OPSEL;
                end else if (is_op_key(key_class) && (cur_st == ST_OPSEL)) begin
                    op_sel_d = op_sel_of(key_class);
                end else if ((key_class == KC_EQUALS) && (cur_st == ST_ENTB)) begin
                    state_d = ST_EXEC;
                end else begin
                    rej_d = 1'b1;
                end
            end
        end else if ((cur_st == ST_EXEC) && exec_ready) begin
            state_d = ST_DONE;
        end
    end

    // State and operand registers; reset drops any pending key or ALU request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_a_q   <= 16'h0000;
            op_b_q   <= 16'h0000;
            op_sel_q <= OPS_ADD;
            rej_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            op_sel_q <= op_sel_d;
            rej_q    <= rej_d;
            ovf_q    <= ovf_d;
        end
    end

    // Output mapping; the request is valid for exactly the EXEC residency.
    always_comb begin
        st         = cur_st;
        ctl_word   = {cur_st, key_class};
        op_a       = op_a_q;
        op_b       = op_b_q;
        op_sel     = op_sel_q;
        exec_valid = (cur_st == ST_EXEC);
        rej        = rej_q;
        ovf        = ovf_q;
    end

endmodule

// File: tb/tb_calc_seq.sv
// Bench for calc_seq: directed scenarios with literal expectations followed
// by randomized key traffic, all compared each cycle against a decimal-value
// model of the calculator.
module tb_calc_seq;

    // Spec codes
    localparam logic [2:0] S_IDLE = 3'd0, S_ENTA = 3'd1, S_OPSEL = 3'd2, S_ENTB = 3'd3;
    localparam logic [2:0] S_EXEC = 3'd4, S_DONE = 3'd6, S_ERR = 3'd7;
    localparam logic [2:0] K_DIG = 3'd0, K_ADD = 3'd1, K_SUB = 3'd2, K_MUL = 3'd3;
    localparam logic [2:0] K_EQ = 3'd4, K_CLR = 3'd5, K_BACK = 3'd6, K_NONE = 3'd7;
    localparam logic [1:0] C_REJ = 2'd0, C_ACC = 2'd1, C_COM = 2'd2, C_ILL = 2'd3;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic [2:0]  key_class = K_NONE;
    logic [3:0]  key_digit = 4'd0;
    logic [1:0]  cont = C_REJ;
    logic        exec_ready = 1'b0;
    logic        key_ready, exec_valid, rej, ovf;
    logic [5:0]  ctl_word;
    logic [15:0] op_a, op_b;
    logic [1:0]  op_sel;
    logic [2:0]  st;

    calc_seq dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_class  (key_class),
        .key_digit  (key_digit),
        .key_ready  (key_ready),
        .ctl_word   (ctl_word),
        .cont       (cont),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_sel     (op_sel),
        .exec_valid (exec_valid),
        .exec_ready (exec_ready),
        .rej        (rej),
        .ovf        (ovf),
        .st         (st)
    );

    // ---------------- scoreboard counters ----------------
    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Operands are kept as plain decimal integers 0..9999.
    logic [2:0] m_st  = S_IDLE;
    int         m_a   = 0;
    int         m_b   = 0;
    logic [1:0] m_sel = 2'd0;
    bit         m_rej = 1'b0;
    bit         m_ovf = 1'b0;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_st = S_IDLE; m_a = 0; m_b = 0; m_sel = 2'd0; m_rej = 0; m_ovf = 0;
        end else begin
            m_rej = 0;
            if (key_valid && m_st != S_EXEC) begin
                if (key_class == K_CLR) begin
                    m_st = S_IDLE; m_a = 0; m_b = 0; m_sel = 2'd0; m_ovf = 0;
                end else if (m_st == S_ERR) begin
                    m_rej = 1;
                end else if (cont == C_REJ || (key_class == K_DIG && key_digit > 9)) begin
                    m_rej = 1;
                end else if (cont == C_ILL) begin
                    m_st = S_ERR;
                end else if (cont == C_ACC) begin
                    if (key_class == K_DIG) begin
                        if (m_st == S_IDLE || m_st == S_DONE) begin
                            m_a = int'(key_digit); m_st = S_ENTA;
                        end else if (m_st == S_OPSEL) begin
                            m_b = int'(key_digit); m_st = S_ENTB;
                        end else if (m_st == S_ENTA) begin
                            if (m_a >= 1000) m_ovf = 1; else m_a = m_a * 10 + int'(key_digit);
                        end else begin
                            if (m_b >= 1000) m_ovf = 1; else m_b = m_b * 10 + int'(key_digit);
                        end
                    end else if (key_class == K_BACK && m_st == S_ENTA) begin
                        m_a = m_a / 10;
                    end else if (key_class == K_BACK && m_st == S_ENTB) begin
                        m_b = m_b / 10;
                    end else begin
                        m_rej = 1;
                    end
                end else begin
                    if (key_class >= K_ADD && key_class <= K_MUL &&
                        (m_st == S_ENTA || m_st == S_DONE || m_st == S_OPSEL)) begin
                        m_sel = 2'(key_class - 3'd1);
                        m_st  = S_OPSEL;
                    end else if (key_class == K_EQ && m_st == S_ENTB) begin
                        m_st = S_EXEC;
                    end else begin
                        m_rej = 1;
                    end
                end
            end else if (m_st == S_EXEC && exec_ready) begin
                m_st = S_DONE;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("st",         32'(st),         32'(m_st));
            check("op_a",       32'(op_a),       32'(to_bcd(m_a)));
            check("op_b",       32'(op_b),       32'(to_bcd(m_b)));
            check("op_sel",     32'(op_sel),     32'(m_sel));
            check("exec_valid", 32'(exec_valid), 32'(m_st == S_EXEC));
            check("key_ready",  32'(key_ready),  32'(m_st != S_EXEC));
            check("rej",        32'(rej),        32'(m_rej));
            check("ovf",        32'(ovf),        32'(m_ovf));
            check("ctl_word",   32'(ctl_word),   32'({m_st, key_class}));
        end
    end

    // ---------------- driver ----------------
    // Inputs change at negedge+1; returns at the following negedge+1.
    task automatic cyc(input bit kv, input logic [2:0] kc, input logic [3:0] kd,
                       input logic [1:0] cn, input bit er, input bit r);
        key_valid  = kv;
        key_class  = kc;
        key_digit  = kd;
        cont       = cn;
        exec_ready = er;
        rst        = r;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic key(input logic [2:0] kc, input logic [3:0] kd, input logic [1:0] cn);
        cyc(1'b1, kc, kd, cn, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cyc(1'b0, K_NONE, 4'd0, C_REJ, 1'b0, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int pick, cpick;
        logic [2:0] kc;
        logic [3:0] kd;
        logic [1:0] cn;

        @(negedge clk); #1;
        do_reset();
        chk_en = 1'b1;
        check("reset_st",   32'(st),         32'(S_IDLE));
        check("reset_op_a", 32'(op_a),       32'h0);
        check("reset_ev",   32'(exec_valid), 32'h0);

        // Digits 1,2,3 then overflow with 4,5, then clear
        key(K_DIG, 4'd1, C_ACC);
        key(K_DIG, 4'd2, C_ACC);
        key(K_DIG, 4'd3, C_ACC);
        check("d123_op_a", 32'(op_a), 32'h0123);
        check("d123_st",   32'(st),   32'(S_ENTA));
        check("d123_rej",  32'(rej),  32'h0);
        key(K_DIG, 4'd4, C_ACC);
        key(K_DIG, 4'd5, C_ACC);
        check("ovf_op_a", 32'(op_a), 32'h1234);
        check("ovf_set",  32'(ovf),  32'h1);
        key(K_CLR, 4'd0, C_REJ);
        check("clr_ovf",  32'(ovf),  32'h0);
        check("clr_op_a", 32'(op_a), 32'h0);
        check("clr_rej",  32'(rej),  32'h0);

        // Backspace and out-of-range digit
        key(K_DIG, 4'd4, C_ACC);
        key(K_DIG, 4'd5, C_ACC);
        key(K_BACK, 4'd0, C_ACC);
        check("bksp_op_a", 32'(op_a), 32'h0004);
        key(K_DIG, 4'd12, C_ACC);
        check("bigdig_rej",  32'(rej),  32'h1);
        check("bigdig_op_a", 32'(op_a), 32'h0004);
        key(K_CLR, 4'd0, C_ACC);

        // 7 + 8 = with ALU stalled for 3 cycles
        key(K_DIG, 4'd7, C_ACC);
        key(K_ADD, 4'd0, C_COM);
        check("opsel_st", 32'(st), 32'(S_OPSEL));
        key(K_DIG, 4'd8, C_ACC);
        key(K_EQ, 4'd0, C_COM);
        for (int i = 0; i < 3; i++) begin
            check("exec_valid_hold", 32'(exec_valid), 32'h1);
            check("exec_kready",     32'(key_ready),  32'h0);
            cyc(1'b1, K_DIG, 4'd9, C_ACC, 1'b0, 1'b0);
        end
        check("exec_valid_4th", 32'(exec_valid), 32'h1);
        check("exec_op_a",      32'(op_a),       32'h0007);
        check("exec_op_b",      32'(op_b),       32'h0008);
        cyc(1'b0, K_NONE, 4'd0, C_REJ, 1'b1, 1'b0);
        check("done_st", 32'(st),         32'(S_DONE));
        check("done_ev", 32'(exec_valid), 32'h0);

        // Rejected digit in IDLE
        do_reset();
        key(K_DIG, 4'd5, C_REJ);
        check("rej_pulse", 32'(rej),  32'h1);
        check("rej_st",    32'(st),   32'(S_IDLE));
        check("rej_op_a",  32'(op_a), 32'h0);
        cyc(1'b0, K_NONE, 4'd0, C_REJ, 1'b0, 1'b0);
        check("rej_gone",  32'(rej),  32'h0);

        // Illegal answer -> ERR, only clear escapes
        key(K_ADD, 4'd0, C_ILL);
        check("err_st", 32'(st), 32'(S_ERR));
        key(K_DIG, 4'd3, C_ACC);
        check("err_rej",    32'(rej), 32'h1);
        check("err_stays",  32'(st),  32'(S_ERR));
        key(K_CLR, 4'd0, C_REJ);
        check("err_clr_st", 32'(st),  32'(S_IDLE));

        // Reset colliding with equals in ENTB
        key(K_DIG, 4'd1, C_ACC);
        key(K_MUL, 4'd0, C_COM);
        key(K_DIG, 4'd2, C_ACC);
        check("entb_op_b", 32'(op_b), 32'h0002);
        check("mul_sel",   32'(op_sel), 32'h2);
        cyc(1'b1, K_EQ, 4'd0, C_COM, 1'b0, 1'b1);
        check("rstcol_st",   32'(st),         32'(S_IDLE));
        check("rstcol_op_b", 32'(op_b),       32'h0);
        check("rstcol_ev",   32'(exec_valid), 32'h0);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            pick = $urandom_range(0, 99);
            if (pick < 45)      kc = K_DIG;
            else if (pick < 58) kc = 3'($urandom_range(1, 3));
            else if (pick < 68) kc = K_EQ;
            else if (pick < 76) kc = K_BACK;
            else if (pick < 80) kc = K_CLR;
            else if (pick < 84) kc = K_NONE;
            else                kc = K_DIG;
            kd = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(10, 15))
                                              : 4'($urandom_range(0, 9));
            cpick = $urandom_range(0, 99);
            if (cpick < 2)       cn = C_ILL;
            else if (cpick < 12) cn = C_REJ;
            else if (cpick < 20) cn = 2'($urandom_range(1, 2));
            else if (kc == K_DIG || kc == K_BACK || kc == K_NONE) cn = C_ACC;
            else cn = C_COM;
            if (cn == C_ILL && kc == K_DIG && kd > 9) kd = kd - 4'd10;
            cyc($urandom_range(0, 9) < 7, kc, kd, cn,
                $urandom_range(0, 2) != 0, $urandom_range(0, 249) == 0);
        end

        cyc(1'b0, K_NONE, 4'd0, C_REJ, 1'b0, 1'b0);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/calc_seq.md
CALC_SEQ -- requirements
Module: calc_seq

Interface
REQ-001 The module SHALL have port clk, input, 1, the single rising-edge clock.
REQ-002 The module SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-003 The module SHALL have port key_valid, input, 1, which is high when a keypad event is offered.
REQ-004 The module SHALL have port key_class, input, 3, encoded as 000 digit, 001 add, 010 sub, 011 mul, 100 equals, 101 clear, 110 backspace, 111 none.
REQ-005 The module SHALL have port key_digit, input, 4, the BCD value, meaningful only when key_class is 000.
REQ-006 The module SHALL have port key_ready, output, 1, which is high when the sequencer can accept a key.
REQ-007 The module SHALL have port ctl_word, output, 6, equal to {state[2:0], key_class[2:0]} and driven to the external control decoder.
REQ-008 The module SHALL have port cont, input, 2, the decoder answer in the same cycle: 00 reject, 01 accept, 10 commit, 11 illegal.
REQ-009 The module SHALL have ports op_a and op_b, outputs, 16 each, holding 4-digit BCD operands with the most significant digit in [15:12].
REQ-010 The module SHALL have port op_sel, output, 2, encoded as 00 add, 01 sub, 10 mul.
REQ-011 The module SHALL have ports exec_valid (output, 1) and exec_ready (input, 1), forming the ALU request handshake.
REQ-012 The module SHALL have ports rej (output, 1), a one-cycle pulse on a rejected key, and ovf (output, 1), a sticky digit-overflow flag.
REQ-013 The module SHALL have port st, output, 3, the current state.

Function
REQ-014 States SHALL be IDLE 000, ENTA 001, OPSEL 010, ENTB 011, EXEC 100, DONE 110, ERR 111; code 101 is unused and SHALL map to ERR.
REQ-015 A key SHALL be taken only on a cycle with key_valid=1 and key_ready=1 (the handshake), and SHALL be sampled together with cont in that same cycle.
REQ-016 key_ready SHALL be 0 in EXEC and 1 in all other states.
REQ-017 A clear key taken in any state SHALL, regardless of cont, go to IDLE, zero op_a, op_b, op_sel and ovf, and not pulse rej.
REQ-018 A handshake with cont=00, or a digit with key_digit>9, SHALL leave state and registers unchanged and pulse rej one cycle later.
REQ-019 cont=11 on a handshake SHALL go to ERR; ERR SHALL accept only a clear key and pulse rej for every other key.
REQ-020 A digit with cont=01 SHALL, when state is IDLE or DONE, load op_a={12'h000,digit} and go to ENTA; when ENTA, shift the digit into op_a from the right; when OPSEL, load op_b={12'h000,digit} and go to ENTB; when ENTB, shift the digit into op_b.
REQ-021 A shift into an operand whose top digit is nonzero SHALL leave that operand unchanged and set ovf.
REQ-022 A backspace with cont=01 in ENTA or ENTB SHALL shift the active operand right by one digit, inserting zero at the top.
REQ-023 An add, sub or mul key with cont=10 in ENTA or DONE SHALL latch op_sel and go to OPSEL; in OPSEL it SHALL only overwrite op_sel.
REQ-024 An equals key with cont=10 in ENTB SHALL go to EXEC.
REQ-025 Any other cont=10 combination SHALL be treated as a reject.
REQ-026 In EXEC, exec_valid SHALL be 1 and op_a, op_b and op_sel SHALL be stable; on exec_valid&&exec_ready the module SHALL go to DONE with exec_valid=0 on the next cycle.
REQ-027 All register updates SHALL occur at the clock edge that ends the handshake cycle, giving 1-cycle latency.

Reset
REQ-028 While rst=1 at a clock edge, the module SHALL set state to IDLE, op_a=0, op_b=0, op_sel=00, exec_valid=0, rej=0 and ovf=0.
REQ-029 Reset SHALL override any simultaneous handshake, including one in EXEC; an abandoned ALU request is dropped.

Structure
REQ-030 The state codes, key_class codes, cont codes and op_sel codes SHALL live in a shared package, calc_pkg.
REQ-031 BCD shift-in, shift-out and overflow detection SHALL be one sub-module, bcd_shift, instantiated once per operand.

Verification
REQ-032 Reset, then digits 1,2,3 each with cont=01, SHALL give op_a=16'h0123, st=ENTA and rej=0.
REQ-033 Digits 1,2,3,4,5 with cont=01 SHALL give op_a=16'h1234 and ovf=1; a following clear SHALL give ovf=0 and op_a=0.
REQ-034 The sequence 7, add(cont=10), 8, equals(cont=10), then exec_ready held 0 for 3 cycles SHALL give exec_valid=1 for 4 cycles and key_ready=0; asserting exec_ready SHALL then give st=DONE.
REQ-035 A digit offered with cont=00 in IDLE SHALL give rej=1 for one cycle, st=IDLE and op_a=0.
REQ-036 A key with cont=11 SHALL give st=ERR; a later digit SHALL give rej=1; a later clear SHALL give st=IDLE.
REQ-037 Asserting rst in the same cycle as an equals handshake in ENTB SHALL give st=IDLE and op_b=0.
